amber_wb_guard: RTL and testbench

Parametrised bus-side wrapper stage between an Amber core (a23/a25) and the system Wishbone interconnect. It registers the core's Wishbone request and returns the slave response one cycle later. A watchdog aborts any cycle the slave never answers and returns an error to the core. A multi-channel event capture path (timer, UART, test-output style strobes) queues observation words into a FIFO for a debug/trace consumer. It generalises the fixed 32-bit pass-through core wrapper: configurable bus width, timeout and channel count.

---
 rtl/amber_wb_guard_pkg.sv | 20 ++
 rtl/amber_evt_fifo.sv | 57 +++++
 rtl/amber_wb_guard.sv | 237 +++++++++++++++++++++++
 tb/tb_amber_wb_guard.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amber_wb_guard_pkg.sv
// Shared types and constants for the Amber Wishbone guard stage:
// bus FSM states, watchdog/drop-counter sizing and channel-index width helper.
package amber_wb_guard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  localparam int WDOG_W = 16;
  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_SAT = 16'hFFFF;

  // A single channel still needs a 1-bit index field in the trace word
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/amber_evt_fifo.sv
// First-word-fall-through FIFO for event trace words; head entry is visible
// on o_data whenever o_empty is low. Push while full is accepted only with a pop.
module amber_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign o_full    = (count_q == (AW+1)'(DEPTH));
  assign o_empty   = (count_q == '0);
  assign do_pop_s  = i_pop && !o_empty;
  assign do_push_s = i_push && (!o_full || do_pop_s);
  assign o_data    = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/amber_wb_guard.sv
// Registered Wishbone stage between an Amber core and the interconnect, with a
// watchdog that aborts unanswered cycles and a multi-channel event trace FIFO.
module amber_wb_guard
  import amber_wb_guard_pkg::*;
#(
  parameter int WB_DWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int EVT_CH         = 4,
  parameter int EVT_WIDTH      = 32,
  parameter int EVT_DEPTH      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [31:0]                   i_core_wb_adr,
  input  logic [WB_DWIDTH/8-1:0]        i_core_wb_sel,
  input  logic                          i_core_wb_we,
  input  logic [WB_DWIDTH-1:0]          i_core_wb_dat,
  input  logic                          i_core_wb_cyc,
  input  logic                          i_core_wb_stb,
  output logic [WB_DWIDTH-1:0]          o_core_wb_dat,
  output logic                          o_core_wb_ack,
  output logic                          o_core_wb_err,
  output logic [31:0]                   o_wb_adr,
  output logic [WB_DWIDTH/8-1:0]        o_wb_sel,
  output logic                          o_wb_we,
  output logic [WB_DWIDTH-1:0]          o_wb_dat,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  input  logic [WB_DWIDTH-1:0]          i_wb_dat,
  input  logic                          i_wb_ack,
  input  logic                          i_wb_err,
  output logic                          o_timeout,
  input  logic                          i_timeout_clr,
  input  logic [EVT_CH-1:0]             i_evt_strobe,
  input  logic [EVT_CH*EVT_WIDTH-1:0]   i_evt_data,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [ch_idx_w(EVT_CH)-1:0]   o_evt_ch,
  output logic [EVT_WIDTH-1:0]          o_evt_data,
  output logic [DROP_W-1:0]             o_evt_drop_cnt
);

  localparam int SW  = WB_DWIDTH / 8;
  localparam int CHW = ch_idx_w(EVT_CH);
  localparam int FW  = CHW + EVT_WIDTH;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  bus_state_e           state_q;
  logic [WDOG_W-1:0]    wdog_q;
  logic [31:0]          wb_adr_q;
  logic [SW-1:0]        wb_sel_q;
  logic                 wb_we_q;
  logic [WB_DWIDTH-1:0] wb_dat_q;
  logic                 wb_cyc_q;
  logic                 wb_stb_q;
  logic [WB_DWIDTH-1:0] core_dat_q;
  logic                 core_ack_q;
  logic                 core_err_q;
  logic                 timeout_q;

  assign o_wb_adr      = wb_adr_q;
  assign o_wb_sel      = wb_sel_q;
  assign o_wb_we       = wb_we_q;
  assign o_wb_dat      = wb_dat_q;
  assign o_wb_cyc      = wb_cyc_q;
  assign o_wb_stb      = wb_stb_q;
  assign o_core_wb_dat = core_dat_q;
  assign o_core_wb_ack = core_ack_q;
  assign o_core_wb_err = core_err_q;
  assign o_timeout     = timeout_q;

  // Bus sequencer: issue, watch for response or watchdog expiry, one-cycle reply
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      wdog_q     <= '0;
      wb_adr_q   <= '0;
      wb_sel_q   <= '0;
      wb_we_q    <= 1'b0;
      wb_dat_q   <= '0;
      wb_cyc_q   <= 1'b0;
      wb_stb_q   <= 1'b0;
      core_dat_q <= '0;
      core_ack_q <= 1'b0;
      core_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // A timeout raised further down overrides this clear
      if (i_timeout_clr) begin
        timeout_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          core_ack_q <= 1'b0;
          core_err_q <= 1'b0;
          if (i_core_wb_cyc && i_core_wb_stb) begin
            wb_adr_q <= i_core_wb_adr;
            wb_sel_q <= i_core_wb_sel;
            wb_we_q  <= i_core_wb_we;
            wb_dat_q <= i_core_wb_dat;
            wb_cyc_q <= 1'b1;
            wb_stb_q <= 1'b1;
            wdog_q   <= '0;
            state_q  <= BUS;
          end
        end
        BUS: begin
          if (i_wb_err) begin
            core_err_q <= 1'b1;
            wb_cyc_q   <= 1'b0;
            wb_stb_q   <= 1'b0;
            state_q    <= RESP;
          end else if (i_wb_ack) begin
            core_ack_q <= 1'b1;
            core_dat_q <= i_wb_dat;
            wb_cyc_q   <= 1'b0;
            wb_stb_q   <= 1'b0;
            state_q    <= RESP;
          end else if (wdog_q == WDOG_LAST) begin
            core_err_q <= 1'b1;
            timeout_q  <= 1'b1;
            wb_cyc_q   <= 1'b0;
            wb_stb_q   <= 1'b0;
            state_q    <= RESP;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        RESP: begin
          core_ack_q <= 1'b0;
          core_err_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          core_ack_q <= 1'b0;
          core_err_q <= 1'b0;
          wb_cyc_q   <= 1'b0;
          wb_stb_q   <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  logic [EVT_CH-1:0]    pend_valid_q;
  logic [EVT_CH-1:0]    pend_valid_d;
  logic [EVT_WIDTH-1:0] pend_data_q [EVT_CH];
  logic [EVT_CH-1:0]    served_s;
  logic [EVT_CH-1:0]    load_s;
  logic [CHW-1:0]       sel_ch_s;
  logic [EVT_WIDTH-1:0] sel_data_s;
  logic                 sel_any_s;
  logic [3:0]           n_drop_s;
  logic [DROP_W:0]      drop_sum_s;
  logic [DROP_W-1:0]    drop_cnt_q;
  logic [DROP_W-1:0]    drop_cnt_d;
  logic                 fifo_push_s;
  logic                 fifo_pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [FW-1:0]        fifo_rdata_s;

  assign fifo_pop_s     = i_evt_ready && !fifo_empty_s;
  assign fifo_push_s    = sel_any_s && (!fifo_full_s || fifo_pop_s);
  assign o_evt_valid    = !fifo_empty_s;
  assign o_evt_ch       = fifo_rdata_s[FW-1:EVT_WIDTH];
  assign o_evt_data     = fifo_rdata_s[EVT_WIDTH-1:0];
  assign o_evt_drop_cnt = drop_cnt_q;

  // Lowest-index pending channel gets the single FIFO write slot
  always_comb begin
    sel_ch_s   = '0;
    sel_data_s = '0;
    for (int c = EVT_CH - 1; c >= 0; c--) begin
      sel_ch_s   = pend_valid_q[c] ? CHW'(c) : sel_ch_s;
      sel_data_s = pend_valid_q[c] ? pend_data_q[c] : sel_data_s;
    end
    sel_any_s = |pend_valid_q;
  end

  // A strobe refills a free or just-drained slot; otherwise it is counted as dropped
  always_comb begin
    pend_valid_d = pend_valid_q;
    served_s     = '0;
    load_s       = '0;
    n_drop_s     = '0;
    for (int c = 0; c < EVT_CH; c++) begin
      served_s[c] = fifo_push_s && (sel_ch_s == CHW'(c));
      if (i_evt_strobe[c] && (!pend_valid_q[c] || served_s[c])) begin
        load_s[c]       = 1'b1;
        pend_valid_d[c] = 1'b1;
      end else if (i_evt_strobe[c]) begin
        n_drop_s = n_drop_s + 4'd1;
      end else if (served_s[c]) begin
        pend_valid_d[c] = 1'b0;
      end else begin
        pend_valid_d[c] = pend_valid_q[c];
      end
    end
    drop_sum_s = {1'b0, drop_cnt_q} + (DROP_W+1)'(n_drop_s);
    drop_cnt_d = drop_sum_s[DROP_W] ? DROP_SAT : drop_sum_s[DROP_W-1:0];
  end

  // Pending slots and saturating drop counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_valid_q <= '0;
      drop_cnt_q   <= '0;
      for (int c = 0; c < EVT_CH; c++) begin
        pend_data_q[c] <= '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      for (int c = 0; c < EVT_CH; c++) begin
        if (load_s[c]) begin
          pend_data_q[c] <= i_evt_data[c*EVT_WIDTH +: EVT_WIDTH];
        end
      end
    end
  end

  amber_evt_fifo #(
    .WIDTH (FW),
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push_s),
    .i_data  ({sel_ch_s, sel_data_s}),
    .i_pop   (fifo_pop_s),
    .o_data  (fifo_rdata_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_amber_wb_guard.sv
// Directed scoreboard bench for amber_wb_guard (128-bit bus, 8-cycle watchdog,
// 4 event channels, 4-deep event FIFO).
module tb_amber_wb_guard;

  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int T  = 8;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } bus_exp_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] dat;
  } evt_exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [31:0]    core_adr;
  logic [SW-1:0]  core_sel;
  logic           core_we;
  logic [DW-1:0]  core_dat;
  logic           core_cyc;
  logic           core_stb;
  logic [DW-1:0]  o_core_wb_dat;
  logic           o_core_wb_ack;
  logic           o_core_wb_err;
  logic [31:0]    o_wb_adr;
  logic [SW-1:0]  o_wb_sel;
  logic           o_wb_we;
  logic [DW-1:0]  o_wb_dat;
  logic           o_wb_cyc;
  logic           o_wb_stb;
  logic [DW-1:0]  wb_rdat;
  logic           wb_ack;
  logic           wb_err;
  logic           o_timeout;
  logic           tclr;
  logic [3:0]     evt_strobe;
  logic [127:0]   evt_data;
  logic           o_evt_valid;
  logic           evt_ready;
  logic [1:0]     o_evt_ch;
  logic [31:0]    o_evt_data;
  logic [15:0]    o_evt_drop_cnt;

  int checks = 0;
  int errors = 0;
  bus_exp_t bus_q[$];
  evt_exp_t evt_q[$];
  logic [31:0]   exp_adr;
  logic [SW-1:0] exp_sel;
  logic          exp_we;
  logic [DW-1:0] exp_wdat;
  logic [DW-1:0] last_ack_dat;
  int n_stb;

  amber_wb_guard #(
    .WB_DWIDTH(DW), .TIMEOUT_CYCLES(T), .EVT_CH(4), .EVT_WIDTH(32), .EVT_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_wb_adr(core_adr), .i_core_wb_sel(core_sel), .i_core_wb_we(core_we),
    .i_core_wb_dat(core_dat), .i_core_wb_cyc(core_cyc), .i_core_wb_stb(core_stb),
    .o_core_wb_dat(o_core_wb_dat), .o_core_wb_ack(o_core_wb_ack), .o_core_wb_err(o_core_wb_err),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_timeout(o_timeout), .i_timeout_clr(tclr),
    .i_evt_strobe(evt_strobe), .i_evt_data(evt_data),
    .o_evt_valid(o_evt_valid), .i_evt_ready(evt_ready),
    .o_evt_ch(o_evt_ch), .o_evt_data(o_evt_data), .o_evt_drop_cnt(o_evt_drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [SW-1:0] sel,
                       input logic [DW-1:0] wdat);
    core_we = we; core_adr = adr; core_sel = sel; core_dat = wdat;
    core_cyc = 1'b1; core_stb = 1'b1;
    exp_we = we; exp_adr = adr; exp_sel = sel; exp_wdat = wdat;
  endtask

  task automatic expect_bus(input logic err, input logic [DW-1:0] dat);
    bus_exp_t e;
    e.err = err;
    e.dat = dat;
    bus_q.push_back(e);
    if (!err) last_ack_dat = dat;
  endtask

  // mode: 0 silent, 1 ack, 2 err, 3 ack+err; responds on the lat-th cycle stb is seen
  task automatic run_txn(input int lat, input int mode, input logic [DW-1:0] rdat, output int n);
    bit done = 1'b0;
    bus_exp_t e;
    n = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0;
      if (o_core_wb_ack || o_core_wb_err) begin
        done = 1'b1;
      end else if (o_wb_stb) begin
        n++;
        chk("wb_adr_hold", DW'(o_wb_adr), DW'(exp_adr));
        chk("wb_sel_hold", DW'(o_wb_sel), DW'(exp_sel));
        chk("wb_we_hold", DW'(o_wb_we), DW'(exp_we));
        chk("wb_dat_hold", o_wb_dat, exp_wdat);
        core_adr = ~exp_adr; core_dat = ~exp_wdat;
        if (n == lat && mode != 0) begin
          wb_ack = (mode == 1 || mode == 3);
          wb_err = (mode == 2 || mode == 3);
          wb_rdat = rdat;
        end
      end
    end
    if (!done) begin
      chk("core_resp_wait", 128'd0, 128'd1);
    end else if (bus_q.size() == 0) begin
      chk("core_resp_unexpected", 128'd1, 128'd0);
    end else begin
      e = bus_q.pop_front();
      chk("core_err", DW'(o_core_wb_err), DW'(e.err));
      chk("core_ack", DW'(o_core_wb_ack), DW'(!e.err));
      chk("core_dat", o_core_wb_dat, e.dat);
      chk("wb_cyc_drop", DW'(o_wb_cyc), 128'd0);
    end
  endtask

  // One cycle after RESP: pulse over, held core stb not reissued
  task automatic finish_txn();
    @(negedge clk);
    chk("ack_one_cycle", DW'(o_core_wb_ack), 128'd0);
    chk("err_one_cycle", DW'(o_core_wb_err), 128'd0);
    chk("no_reissue", DW'(o_wb_stb), 128'd0);
    core_cyc = 1'b0; core_stb = 1'b0;
  endtask

  task automatic evt_push(input logic [1:0] ch, input logic [31:0] d);
    evt_exp_t e;
    e.ch = ch;
    e.dat = d;
    evt_q.push_back(e);
  endtask

  task automatic evt_head_chk(input bit pop);
    evt_exp_t e;
    chk("evt_valid", DW'(o_evt_valid), 128'd1);
    if (evt_q.size() == 0) begin
      chk("evt_unexpected", DW'(o_evt_valid), 128'd0);
    end else begin
      e = evt_q[0];
      if (pop) void'(evt_q.pop_front());
      chk("evt_ch", DW'(o_evt_ch), DW'(e.ch));
      chk("evt_data", DW'(o_evt_data), DW'(e.dat));
    end
  endtask

  task automatic strobe_ch(input int ch, input logic [31:0] d);
    evt_strobe = 4'd0;
    evt_strobe[ch] = 1'b1;
    evt_data[ch*32 +: 32] = d;
  endtask

  initial begin
    rst_n = 1'b0; core_adr = 32'd0; core_sel = '0; core_we = 1'b0; core_dat = '0;
    core_cyc = 1'b0; core_stb = 1'b0; wb_rdat = '0; wb_ack = 1'b0; wb_err = 1'b0;
    tclr = 1'b0; evt_strobe = 4'd0; evt_data = '0; evt_ready = 1'b1;
    last_ack_dat = '0;

    repeat (2) @(negedge clk);
    chk("rst_wb_cyc", DW'(o_wb_cyc), 128'd0);
    chk("rst_wb_stb", DW'(o_wb_stb), 128'd0);
    chk("rst_core_ack", DW'(o_core_wb_ack), 128'd0);
    chk("rst_core_err", DW'(o_core_wb_err), 128'd0);
    chk("rst_core_dat", o_core_wb_dat, 128'd0);
    chk("rst_timeout", DW'(o_timeout), 128'd0);
    chk("rst_evt_valid", DW'(o_evt_valid), 128'd0);
    chk("rst_evt_data", DW'({o_evt_ch, o_evt_data}), 128'd0);
    chk("rst_drop", DW'(o_evt_drop_cnt), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read, slave acks on 3rd stb cycle
    issue(1'b0, 32'h0000_1000, 16'hFFFF, 128'd0);
    expect_bus(1'b0, 128'hDEADBEEF);
    run_txn(3, 1, 128'hDEADBEEF, n_stb);
    chk("read_stb_cycles", DW'(n_stb), 128'd3);
    finish_txn();

    // Silent slave: watchdog abort after T bus cycles
    @(negedge clk);
    issue(1'b0, 32'h0000_2000, 16'h000F, 128'd0);
    expect_bus(1'b1, last_ack_dat);
    run_txn(0, 0, 128'd0, n_stb);
    chk("to_stb_cycles", DW'(n_stb), DW'(T));
    chk("to_flag_set", DW'(o_timeout), 128'd1);
    finish_txn();
    chk("to_flag_sticky", DW'(o_timeout), 128'd1);
    tclr = 1'b1;
    @(negedge clk);
    tclr = 1'b0;
    chk("to_flag_clr", DW'(o_timeout), 128'd0);

    // Clear held through a new timeout: set wins
    tclr = 1'b1;
    issue(1'b1, 32'h0000_3000, 16'h00FF, 128'h55);
    expect_bus(1'b1, last_ack_dat);
    run_txn(0, 0, 128'd0, n_stb);
    chk("to_set_wins", DW'(o_timeout), 128'd1);
    tclr = 1'b0;
    finish_txn();
    tclr = 1'b1;
    @(negedge clk);
    tclr = 1'b0;
    chk("to_flag_clr2", DW'(o_timeout), 128'd0);

    // ack and err together: err wins, read data held
    issue(1'b0, 32'h0000_4000, 16'hFFFF, 128'd0);
    expect_bus(1'b1, last_ack_dat);
    run_txn(2, 3, 128'h1234, n_stb);
    finish_txn();
    chk("err_no_timeout", DW'(o_timeout), 128'd0);

    // ack on final watchdog cycle beats the timeout
    @(negedge clk);
    issue(1'b0, 32'h0000_5000, 16'hFFFF, 128'd0);
    expect_bus(1'b0, 128'hCAFE_0000_0000_0000_0000_0000_5A5A_0001);
    run_txn(T, 1, 128'hCAFE_0000_0000_0000_0000_0000_5A5A_0001, n_stb);
    chk("last_ack_cycles", DW'(n_stb), DW'(T));
    chk("last_ack_no_timeout", DW'(o_timeout), 128'd0);
    finish_txn();

    // 128-bit write, partial sel, minimum latency
    @(negedge clk);
    issue(1'b1, 32'h2000_0040, 16'h00F0, 128'h0123456789ABCDEF_FEDCBA9876543210);
    expect_bus(1'b0, 128'd0);
    run_txn(1, 1, 128'd0, n_stb);
    chk("wr_stb_cycles", DW'(n_stb), 128'd1);
    finish_txn();

    // Events: ch2+ch0 together, then a ch2 strobe while ch2 still pending
    @(negedge clk);
    evt_strobe = 4'b0101;
    evt_data[0 +: 32] = 32'hA000_0000;
    evt_data[64 +: 32] = 32'hA000_0002;
    evt_push(2'd0, 32'hA000_0000);
    evt_push(2'd2, 32'hA000_0002);
    @(negedge clk);
    chk("evt_lat_pending", DW'(o_evt_valid), 128'd0);
    strobe_ch(2, 32'hB000_0002);
    @(negedge clk);
    evt_strobe = 4'd0;
    evt_head_chk(1'b1);
    @(negedge clk);
    evt_head_chk(1'b1);
    @(negedge clk);
    chk("evt_empty_a", DW'(o_evt_valid), 128'd0);
    chk("evt_drop_1", DW'(o_evt_drop_cnt), 128'd1);

    // Backpressure: 6 ch1 strobes into a 4-deep FIFO
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      strobe_ch(1, 32'h100 + 32'(k));
      if (k < 5) evt_push(2'd1, 32'h100 + 32'(k));
      @(negedge clk);
      evt_strobe = 4'd0;
      @(negedge clk);
    end
    @(negedge clk);
    chk("evt_drop_2", DW'(o_evt_drop_cnt), 128'd2);
    evt_head_chk(1'b0);
    evt_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (o_evt_valid) evt_head_chk(1'b1);
      else if (evt_q.size() == 0) break;
      @(negedge clk);
    end
    chk("evt_all_drained", DW'(evt_q.size()), 128'd0);
    chk("evt_empty_b", DW'(o_evt_valid), 128'd0);

    // Prime state, then reset mid-BUS
    evt_ready = 1'b0;
    strobe_ch(3, 32'hC3);
    @(negedge clk);
    evt_strobe = 4'd0;
    repeat (2) @(negedge clk);
    chk("pre_rst_evt_valid", DW'(o_evt_valid), 128'd1);
    issue(1'b0, 32'h0000_6000, 16'hFFFF, 128'd0);
    expect_bus(1'b1, last_ack_dat);
    run_txn(0, 0, 128'd0, n_stb);
    finish_txn();
    chk("pre_rst_timeout", DW'(o_timeout), 128'd1);
    issue(1'b0, 32'h0000_7000, 16'hFFFF, 128'd0);
    repeat (2) @(negedge clk);
    chk("pre_rst_cyc", DW'(o_wb_cyc), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", DW'(o_wb_cyc), 128'd0);
    chk("rst_mid_stb", DW'(o_wb_stb), 128'd0);
    chk("rst_mid_timeout", DW'(o_timeout), 128'd0);
    chk("rst_mid_evt_valid", DW'(o_evt_valid), 128'd0);
    chk("rst_mid_drop", DW'(o_evt_drop_cnt), 128'd0);
    core_cyc = 1'b0; core_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_ack", DW'(o_core_wb_ack | o_core_wb_err), 128'd0);
      chk("post_rst_cyc", DW'(o_wb_cyc), 128'd0);
    end
    chk("bus_sb_empty", DW'(bus_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
